alu_sequencer: RTL and testbench

//  Multi-cycle controller that sequences the 3-bit-opcode ALU (ADD/SUB/AND/OR/XOR) against a small register file.

---
 rtl/alu_sequencer_if.sv | 48 ++++
 rtl/alu_sequencer.sv | 116 +++++++++++
 tb/tb_alu_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction, register-load and debug bus of the ALU sequencer.
//   master (decode logic / bench) drives:
//     in_valid, in_opcode, in_rd, in_rs1, in_rs2 : instruction request
//     ld_valid, ld_addr, ld_data                 : single-cycle register load
//     dbg_addr                                   : debug read address
//   slave (alu_sequencer) drives:
//     in_ready, done, err                        : handshake and retire pulses
//     dbg_data                                   : combinational regs[dbg_addr]
//     zero_flag                                  : only with STATUS_FLAGS_EN defined
interface alu_sequencer_if #(
    parameter int DATAWIDTH = 32,
    parameter int NREGS     = 4
);
    localparam int AW = $clog2(NREGS);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_opcode;
    logic [AW-1:0]        in_rd;
    logic [AW-1:0]        in_rs1;
    logic [AW-1:0]        in_rs2;
    logic                 ld_valid;
    logic [AW-1:0]        ld_addr;
    logic [DATAWIDTH-1:0] ld_data;
    logic                 done;
    logic                 err;
    logic [AW-1:0]        dbg_addr;
    logic [DATAWIDTH-1:0] dbg_data;
`ifdef STATUS_FLAGS_EN
    logic                 zero_flag;
    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, ld_valid, ld_addr, ld_data, dbg_addr,
        input  in_ready, done, err, dbg_data, zero_flag
    );
    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, ld_valid, ld_addr, ld_data, dbg_addr,
        output in_ready, done, err, dbg_data, zero_flag
    );
`else
    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, ld_valid, ld_addr, ld_data, dbg_addr,
        input  in_ready, done, err, dbg_data
    );
    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, ld_valid, ld_addr, ld_data, dbg_addr,
        output in_ready, done, err, dbg_data
    );
`endif
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller running register-register ALU ops on a small register file.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : alu_sequencer_if.slave (instruction handshake, load port, done/err, debug read)
//   Optional macro STATUS_FLAGS_EN adds the registered zero_flag output.
//   Sequence per instruction: IDLE -> FETCH -> EXEC -> WB -> IDLE (one op per 4 cycles).
module alu_sequencer_alu #(
    parameter int DATAWIDTH = 32
) (
    input  logic [2:0]           i_opcode,
    input  logic [DATAWIDTH-1:0] i_data1,
    input  logic [DATAWIDTH-1:0] i_data2,
    output logic [DATAWIDTH-1:0] o_result,
    output logic                 o_illegal
);
    always_comb begin
        o_illegal = i_opcode > 3'd4;
        o_result  = i_opcode == 3'd0 ? i_data1 + i_data2 :
                    i_opcode == 3'd1 ? i_data1 - i_data2 :
                    i_opcode == 3'd2 ? i_data1 & i_data2 :
                    i_opcode == 3'd3 ? i_data1 | i_data2 :
                                       i_data1 ^ i_data2;
    end
endmodule

module alu_sequencer #(
    parameter int DATAWIDTH = 32,
    parameter int NREGS     = 4
) (
    input logic            clk,
    input logic            reset,
    alu_sequencer_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
    state_t               r_state;
    state_t               w_next;
    logic [DATAWIDTH-1:0] r_regs [NREGS];
    logic [2:0]           r_op;
    logic [AW-1:0]        r_rd;
    logic [AW-1:0]        r_rs1;
    logic [AW-1:0]        r_rs2;
    logic [DATAWIDTH-1:0] r_op1;
    logic [DATAWIDTH-1:0] r_op2;
    logic [DATAWIDTH-1:0] r_res;
    logic [DATAWIDTH-1:0] w_alu_res;
    logic                 w_illegal;
    logic                 w_accept;
    logic                 w_load;

    // The ALU stays wired to the operand registers; r_op is stable through WB,
    // so its illegal flag doubles as the err/done selector there.
    alu_sequencer_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
        .i_opcode (r_op),
        .i_data1  (r_op1),
        .i_data2  (r_op2),
        .o_result (w_alu_res),
        .o_illegal(w_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // A load in IDLE takes priority over an instruction, so ready is withheld that cycle.
    always_comb begin
        bus.in_ready = !reset && r_state == IDLE && !bus.ld_valid;
        bus.done     = r_state == WB && !w_illegal;
        bus.err      = r_state == WB && w_illegal;
        w_accept     = bus.in_valid && bus.in_ready;
        w_load       = r_state == IDLE && bus.ld_valid;
        w_next       = r_state == IDLE  ? (w_accept ? FETCH : IDLE) :
                       r_state == FETCH ? EXEC :
                       r_state == EXEC  ? WB : IDLE;
    end

    // Register 0 is never written, so reads of it always return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_op  <= '0;
            r_rd  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_op1 <= '0;
            r_op2 <= '0;
            r_res <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= bus.in_opcode;
                r_rd  <= bus.in_rd;
                r_rs1 <= bus.in_rs1;
                r_rs2 <= bus.in_rs2;
            end
            if (r_state == FETCH) begin
                r_op1 <= r_regs[r_rs1];
                r_op2 <= r_regs[r_rs2];
            end
            if (r_state == EXEC) r_res <= w_alu_res;
            if (w_load && bus.ld_addr != '0) r_regs[bus.ld_addr] <= bus.ld_data;
            if (bus.done && r_rd != '0) r_regs[r_rd] <= r_res;
        end
    end

    assign bus.dbg_data = r_regs[bus.dbg_addr];

`ifdef STATUS_FLAGS_EN
    logic r_zero;
    always_ff @(posedge clk) begin
        if (reset)         r_zero <= 1'b0;
        else if (bus.done) r_zero <= r_res == '0;
    end
    assign bus.zero_flag = r_zero;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks of alu_sequencer against a register-file model.
module tb_alu_sequencer;
    localparam int DW = 32;
    localparam int NR = 4;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [DW-1:0] m_regs [NR];
    logic          m_zf;

    always #5 clk = ~clk;

    alu_sequencer_if #(.DATAWIDTH(DW), .NREGS(NR)) bus ();
    alu_sequencer #(.DATAWIDTH(DW), .NREGS(NR)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk_reg(input string tag, input int a);
        bus.dbg_addr = 2'(a);
        #1;
        check(tag, bus.dbg_data, m_regs[a]);
    endtask

    task automatic chk_const(input string tag, input int a, input logic [DW-1:0] exp);
        bus.dbg_addr = 2'(a);
        #1;
        check(tag, bus.dbg_data, exp);
    endtask

    task automatic chk_zf(input string tag);
`ifdef STATUS_FLAGS_EN
        check(tag, DW'(bus.zero_flag), DW'(m_zf));
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    task automatic chk_all(input string tag);
        @(negedge clk);
        for (int i = 0; i < NR; i++) chk_reg(tag, i);
    endtask

    task automatic do_load(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 2'(a);
        bus.ld_data  = d;
        #1;
        check("ld_ready_low", DW'(bus.in_ready), 0);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        if (a != 0) m_regs[a] = d;
        chk_reg("ld_reg", a);
    endtask

    task automatic noise(input bit noisy);
        bus.in_valid  = 1'($urandom);
        bus.in_opcode = 3'($urandom);
        bus.in_rd     = 2'($urandom);
        bus.in_rs1    = 2'($urandom);
        bus.in_rs2    = 2'($urandom);
        bus.ld_valid  = noisy;
        bus.ld_addr   = 2'($urandom);
        bus.ld_data   = $urandom;
    endtask

    // Timeline: accept at T, FETCH T+1, EXEC T+2, done/err at T+3, ready again at T+4.
    task automatic run_op(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                          input bit noisy, input bit now);
        logic [DW-1:0] res;
        bit legal;
        legal = op <= 3'd4;
        if (!now) @(negedge clk);
        bus.ld_valid  = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_rd     = 2'(rd);
        bus.in_rs1    = 2'(rs1);
        bus.in_rs2    = 2'(rs2);
        #1;
        check("acc_ready", DW'(bus.in_ready), 1);
        res = ref_alu(op, m_regs[rs1], m_regs[rs2]);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            noise(noisy);
            #1;
            check("busy_ready", DW'(bus.in_ready), 0);
            check("busy_done", DW'(bus.done), 0);
            check("busy_err", DW'(bus.err), 0);
        end
        @(negedge clk);
        noise(noisy);
        #1;
        check("wb_done", DW'(bus.done), DW'(legal));
        check("wb_err", DW'(bus.err), DW'(!legal));
        check("wb_ready", DW'(bus.in_ready), 0);
        chk_reg("wb_old", rd);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ld_valid = 1'b0;
        #1;
        check("post_ready", DW'(bus.in_ready), 1);
        check("post_done", DW'(bus.done), 0);
        check("post_err", DW'(bus.err), 0);
        if (legal) begin
            if (rd != 0) m_regs[rd] = res;
            m_zf = res == '0;
        end
        chk_reg("wb_new", rd);
        chk_zf("zero_flag");
    endtask

    initial begin
        bit fresh;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_opcode = '0;
        bus.in_rd    = '0;
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.dbg_addr = '0;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_zf = 1'b0;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        check("rst_ready", DW'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_ready_rel", DW'(bus.in_ready), 1);
        check("rst_done", DW'(bus.done), 0);
        check("rst_err", DW'(bus.err), 0);
        chk_zf("rst_zf");
        chk_all("rst_regs");

        // Reset in EXEC of an ADD drops the op.
        do_load(1, 32'd5);
        do_load(2, 32'd3);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_opcode = 3'd0; bus.in_rd = 2'd3; bus.in_rs1 = 2'd1; bus.in_rs2 = 2'd2;
        #1;
        check("t1_acc", DW'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t1_ready_rst", DW'(bus.in_ready), 0);
        @(negedge clk);
        check("t1_done", DW'(bus.done), 0);
        reset = 1'b0;
        #1;
        check("t1_ready", DW'(bus.in_ready), 1);
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_zf = 1'b0;
        for (int i = 0; i < NR; i++) chk_const("t1_regs", i, '0);
        repeat (3) begin
            @(negedge clk);
            check("t1_no_done", DW'(bus.done), 0);
        end

        // ADD then SUB wrap-around.
        do_load(1, 32'd5);
        do_load(2, 32'd3);
        run_op(3'd0, 3, 1, 2, 1'b0, 1'b0);
        chk_const("t2_add", 3, 32'd8);
        run_op(3'd1, 3, 2, 1, 1'b0, 1'b0);
        chk_const("t2_sub", 3, 32'hFFFF_FFFE);
`ifdef STATUS_FLAGS_EN
        check("t2_zf", DW'(bus.zero_flag), 0);
`endif

        // Logic ops.
        do_load(1, 32'hF0F0);
        do_load(2, 32'h0FF0);
        run_op(3'd2, 3, 1, 2, 1'b0, 1'b0);
        chk_const("t3_and", 3, 32'h00F0);
        run_op(3'd3, 3, 1, 2, 1'b0, 1'b0);
        chk_const("t3_or", 3, 32'hFFF0);
        run_op(3'd4, 3, 1, 2, 1'b0, 1'b0);
        chk_const("t3_xor", 3, 32'hFF00);
        run_op(3'd4, 3, 1, 1, 1'b0, 1'b0);
        chk_const("t3_xor0", 3, 32'h0);
`ifdef STATUS_FLAGS_EN
        check("t3_zf", DW'(bus.zero_flag), 1);
`endif

        // Illegal opcodes, second accepted at T+4.
        run_op(3'd6, 1, 2, 3, 1'b0, 1'b0);
        run_op(3'd7, 1, 2, 3, 1'b0, 1'b1);
        chk_const("t4_r1", 1, 32'hF0F0);

        // Load wins over a simultaneous instruction; load during EXEC dropped.
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 32'd7;
        bus.in_valid = 1'b1; bus.in_opcode = 3'd0; bus.in_rd = 2'd2; bus.in_rs1 = 2'd1; bus.in_rs2 = 2'd1;
        #1;
        check("t5_ready", DW'(bus.in_ready), 0);
        @(negedge clk);
        m_regs[1] = 32'd7;
        run_op(3'd0, 2, 1, 1, 1'b1, 1'b1);
        chk_const("t5_add", 2, 32'd14);
        chk_all("t5_regs");

        // Register 0 stays zero.
        do_load(0, 32'hDEAD);
        chk_const("t6_ld", 0, '0);
        run_op(3'd0, 0, 1, 2, 1'b0, 1'b0);
        chk_const("t6_add", 0, '0);

        // Randomized traffic.
        fresh = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_load($urandom_range(0, NR - 1),
                        $urandom_range(0, 3) == 0 ? DW'($urandom_range(0, 3)) : DW'($urandom));
            else
                run_op(3'($urandom_range(0, 7)), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                       $urandom_range(0, NR - 1), 1'($urandom), fresh ? 1'b0 : 1'($urandom));
            fresh = 1'b0;
            if (i % 10 == 9) begin
                chk_all("rnd_regs");
                fresh = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
